// File: rtl/mole_round_ctrl.sv
// Whac-a-mole round sequencer: chooses a hole, keeps the mole up for a fixed time,
// and scores button presses as hits or misses.
module mole_round_ctrl #(
    parameter int         UP_CYCLES  = 25_000_000,
    parameter int         GAP_CYCLES = 12_500_000,
    parameter int         MAX_MISSES = 3,
    parameter int         SCORE_BITS = 8,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            btn,
    output logic [1:0]            mole_sel,
    output logic                  mole_valid,
    output logic [SCORE_BITS-1:0] score,
    output logic [3:0]            misses,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
    output logic                  game_over
);

    localparam int CNT_MAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0]         UP_LOAD    = CW'(UP_CYCLES - 1);
    localparam logic [CW-1:0]         GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [SCORE_BITS-1:0] SCORE_MAX  = '1;
    localparam logic [3:0]            MISS_LIMIT = 4'(MAX_MISSES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_UP,
        S_HIT,
        S_MISS,
        S_OVER
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    lfsr;
    logic [3:0]    btn_q;

    logic [3:0] press;
    logic [3:0] target;
    logic       lfsr_fb;
    logic [1:0] pick;
    logic [1:0] next_sel;

    always_comb begin
        press    = btn & ~btn_q;
        target   = 4'b0001 << mole_sel;
        lfsr_fb  = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        pick     = lfsr[1:0];
        // Never show the same hole twice in a row; the 2-bit add wraps 3 -> 0.
        next_sel = (pick == mole_sel) ? pick + 2'd1 : pick;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lfsr       <= LFSR_SEED;
            btn_q      <= '0;
            mole_sel   <= '0;
            mole_valid <= 1'b0;
            score      <= '0;
            misses     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            lfsr       <= {lfsr[6:0], lfsr_fb};
            btn_q      <= btn;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_GAP;
                        cnt    <= GAP_LOAD;
                        score  <= '0;
                        misses <= '0;
                    end
                end

                S_GAP: begin
                    if (cnt == '0) begin
                        state      <= S_UP;
                        cnt        <= UP_LOAD;
                        mole_sel   <= next_sel;
                        mole_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_UP: begin
                    // A clean press of the lit hole wins even on the final cycle.
                    if (press == target) begin
                        state      <= S_HIT;
                        mole_valid <= 1'b0;
                        hit_pulse  <= 1'b1;
                        if (score != SCORE_MAX) begin
                            score <= score + SCORE_BITS'(1);
                        end
                    end else if (press != 4'b0000 || cnt == '0) begin
                        state      <= S_MISS;
                        mole_valid <= 1'b0;
                        miss_pulse <= 1'b1;
                        misses     <= misses + 4'd1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_HIT: begin
                    state <= S_GAP;
                    cnt   <= GAP_LOAD;
                end

                S_MISS: begin
                    if (misses == MISS_LIMIT) begin
                        state     <= S_OVER;
                        game_over <= 1'b1;
                    end else begin
                        state <= S_GAP;
                        cnt   <= GAP_LOAD;
                    end
                end

                S_OVER: begin
                    if (start) begin
                        state     <= S_GAP;
                        cnt       <= GAP_LOAD;
                        score     <= '0;
                        misses    <= '0;
                        game_over <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Table-driven bench for mole_round_ctrl: per-cycle records of inputs and expected
// outputs, with hole selection predicted from an independent LFSR model.
`timescale 1ns/1ps
module tb_mole_round_ctrl;

    localparam int         UP   = 4;
    localparam int         GAP  = 2;
    localparam int         MAXM = 3;
    localparam int         SB   = 3;
    localparam logic [7:0] SEED = 8'hA5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    btn;
    logic [1:0]    mole_sel;
    logic          mole_valid;
    logic [SB-1:0] score;
    logic [3:0]    misses;
    logic          hit_pulse;
    logic          miss_pulse;
    logic          game_over;

    always #5 clk = ~clk;

    mole_round_ctrl #(
        .UP_CYCLES (UP),
        .GAP_CYCLES(GAP),
        .MAX_MISSES(MAXM),
        .SCORE_BITS(SB),
        .LFSR_SEED (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .btn       (btn),
        .mole_sel  (mole_sel),
        .mole_valid(mole_valid),
        .score     (score),
        .misses    (misses),
        .hit_pulse (hit_pulse),
        .miss_pulse(miss_pulse),
        .game_over (game_over)
    );

    // Button ops are resolved when applied, since the hole is only known at run time.
    typedef enum int {B_NONE, B_OK, B_WRONG, B_BOTH, B_NEXT, B_HOLD} bop_t;

    typedef struct {
        logic       rst;
        logic       st;
        bop_t       op;
        logic       valid;
        logic       hit;
        logic       miss;
        logic [2:0] score;
        logic [3:0] misses;
        logic       over;
    } vec_t;

    vec_t        tbl[$];
    logic [12:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          es = 0;
    int          em = 0;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [1:0] pred_sel(input logic [7:0] l, input logic [1:0] prev);
        logic [1:0] s;
        s = l[1:0];
        if (s == prev) s = s + 2'd1;
        return s;
    endfunction

    task automatic add(input logic rst, input logic st, input bop_t op,
                       input logic v, input logic h, input logic m, input logic over);
        vec_t r;
        r.rst    = rst;
        r.st     = st;
        r.op     = op;
        r.valid  = v;
        r.hit    = h;
        r.miss   = m;
        r.score  = 3'(es);
        r.misses = 4'(em);
        r.over   = over;
        tbl.push_back(r);
    endtask

    task automatic add_reset();
        es = 0;
        em = 0;
        add(1'b1, 1'b0, B_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_start();
        es = 0;
        em = 0;
        add(1'b0, 1'b1, B_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Starts in the first gap cycle; press_at=0 means no press (timeout).
    task automatic add_round(input int press_at, input bop_t op, input bop_t gap_op,
                             input logic st_up);
        bop_t fill;
        logic done;
        fill = (gap_op == B_NEXT) ? B_HOLD : B_NONE;
        done = 1'b0;
        add(1'b0, 1'b0, B_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, gap_op, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= UP; c++) begin
            if (!done) begin
                if (c == press_at && op == B_OK) begin
                    es = (es == 7) ? 7 : es + 1;
                    add(1'b0, st_up, op, 1'b0, 1'b1, 1'b0, 1'b0);
                    done = 1'b1;
                end else if (c == press_at) begin
                    em = em + 1;
                    add(1'b0, st_up, op, 1'b0, 1'b0, 1'b1, 1'b0);
                    done = 1'b1;
                end else if (c == UP) begin
                    em = em + 1;
                    add(1'b0, st_up, fill, 1'b0, 1'b0, 1'b1, 1'b0);
                    done = 1'b1;
                end else begin
                    add(1'b0, st_up, fill, 1'b1, 1'b0, 1'b0, 1'b0);
                end
            end
        end
        add(1'b0, 1'b0, B_NONE, 1'b0, 1'b0, 1'b0, logic'(em == MAXM));
    endtask

    initial begin
        logic [3:0]  b;
        logic [3:0]  btn_prev;
        logic [1:0]  exp_sel;
        logic [1:0]  nsel;
        logic [1:0]  last_rise_sel;
        logic [7:0]  m_lfsr;
        logic        prev_valid;
        logic [12:0] exp_v;
        logic [12:0] act_v;
        logic [3:0]  holes_hit;
        int          rises;
        int          repeats;
        vec_t        r;

        // Game 1: timeout, hit, held button, wrong button (start during UP ignored).
        add_reset();
        add_start();
        add_round(0, B_NONE, B_NONE, 1'b0);
        add_round(2, B_OK, B_NONE, 1'b0);
        add_round(0, B_NONE, B_NEXT, 1'b0);
        add_round(1, B_WRONG, B_NONE, 1'b1);
        add(1'b0, 1'b0, B_OK, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, B_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        // Game 2: three timeouts in a row.
        add_start();
        for (int k = 0; k < 3; k++) add_round(0, B_NONE, B_NONE, 1'b0);
        add(1'b0, 1'b0, B_NONE, 1'b0, 1'b0, 1'b0, 1'b1);
        // Game 3: both buttons, last-cycle hit, saturation, long random run.
        add_start();
        add_round(3, B_BOTH, B_NONE, 1'b0);
        add_round(4, B_OK, B_NONE, 1'b0);
        for (int k = 0; k < 8; k++) add_round(1, B_OK, B_NONE, 1'b0);
        for (int k = 0; k < 200; k++) add_round($urandom_range(1, UP), B_OK, B_NONE, 1'b0);
        // Reset while the mole is up, then a fresh game.
        add(1'b0, 1'b0, B_NONE, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, B_NONE, 1'b1, 1'b0, 1'b0, 1'b0);
        add_reset();
        add_start();
        add_round(0, B_NONE, B_NONE, 1'b0);

        reset         = 1'b1;
        start         = 1'b0;
        btn           = 4'b0000;
        btn_prev      = 4'b0000;
        exp_sel       = 2'd0;
        last_rise_sel = 2'd0;
        m_lfsr        = SEED;
        prev_valid    = 1'b0;
        holes_hit     = 4'b0000;
        rises         = 0;
        repeats       = 0;

        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i];
            case (r.op)
                B_OK:    b = 4'b0001 << exp_sel;
                B_WRONG: b = 4'b0001 << 2'(exp_sel + 2'd1);
                B_BOTH:  b = (4'b0001 << exp_sel) | (4'b0001 << 2'(exp_sel + 2'd1));
                B_NEXT:  b = 4'b0001 << pred_sel(m_lfsr, exp_sel);
                B_HOLD:  b = btn_prev;
                default: b = 4'b0000;
            endcase
            reset = r.rst;
            start = r.st;
            btn   = b;

            if (r.rst) nsel = 2'd0;
            else if (r.valid && !prev_valid) nsel = pred_sel(m_lfsr, exp_sel);
            else nsel = exp_sel;
            exp_q.push_back({nsel, r.valid, r.hit, r.miss, r.score, r.misses, r.over});

            @(posedge clk);
            m_lfsr = r.rst ? SEED : lfsr_step(m_lfsr);
            #1;

            exp_v = exp_q.pop_front();
            act_v = {mole_sel, mole_valid, hit_pulse, miss_pulse, score, misses, game_over};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL row%0d {sel,valid,hit,miss,score,misses,over}: got %0d,%b,%b,%b,%0d,%0d,%b expected %0d,%b,%b,%b,%0d,%0d,%b",
                         i, act_v[12:11], act_v[10], act_v[9], act_v[8], act_v[7:5], act_v[4:1], act_v[0],
                         exp_v[12:11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:5], exp_v[4:1], exp_v[0]);
            end

            if (mole_valid && !prev_valid && !r.rst) begin
                if (rises > 0 && mole_sel == last_rise_sel) repeats++;
                last_rise_sel = mole_sel;
                rises++;
            end
            if (r.hit && hit_pulse) holes_hit[exp_sel] = 1'b1;

            exp_sel    = nsel;
            prev_valid = r.valid;
            btn_prev   = b;
        end

        checks++;
        if (holes_hit !== 4'b1111) begin
            errors++;
            $display("FAIL holes_hit: got %b expected 1111", holes_hit);
        end
        checks++;
        if (repeats != 0 || rises < 200) begin
            errors++;
            $display("FAIL sel_repeat: got repeats=%0d rises=%0d expected repeats=0 rises>=200", repeats, rises);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
